// File: rtl/pipe_regfile_sb_if.sv
// pipe_regfile_sb_if
// Bundles the decode/writeback/issue traffic of the scoreboarded register file.
//   master : pipeline side (drives read addresses, writeback, issue, cancel)
//   slave  : register file side (returns read data, busy, issue ready, underflow)
// Signals:
//   rd_addr_i     packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data_o     packed read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy_o     per-port outstanding-writer flag
//   we_i/wa_i/wd_i            writeback enable, address, data
//   issue_i/issue_addr_i      destination entering EX
//   issue_ready_o             issue accepted this cycle
//   cancel_i/cancel_addr_i    squashed in-flight writer
//   underflow_o               sticky pending-count underflow
interface pipe_regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic [NUM_RD-1:0]        rd_busy_o;
    logic                     we_i;
    logic [ADDR_W-1:0]        wa_i;
    logic [DATA_W-1:0]        wd_i;
    logic                     issue_i;
    logic [ADDR_W-1:0]        issue_addr_i;
    logic                     issue_ready_o;
    logic                     cancel_i;
    logic [ADDR_W-1:0]        cancel_addr_i;
    logic                     underflow_o;

    modport master (
        output rd_addr_i, we_i, wa_i, wd_i, issue_i, issue_addr_i, cancel_i, cancel_addr_i,
        input  rd_data_o, rd_busy_o, issue_ready_o, underflow_o
    );

    modport slave (
        input  rd_addr_i, we_i, wa_i, wd_i, issue_i, issue_addr_i, cancel_i, cancel_addr_i,
        output rd_data_o, rd_busy_o, issue_ready_o, underflow_o
    );
endinterface

// File: rtl/pipe_regfile_sb.sv
// pipe_regfile_sb
// Register file with a per-register pending-writer counter (scoreboard).
// Decode reads combinationally, WB writes on the clock edge, and each
// issued destination bumps that register's counter until its writeback
// or cancel retires it.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset (clears data, counters, underflow)
//   bus    pipe_regfile_sb_if.slave (reads, writeback, issue, cancel, status)
module pipe_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int PEND_W   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pipe_regfile_sb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0]        regs    [DEPTH];
    logic [PEND_W-1:0]        cnt     [DEPTH];
    logic [PEND_W-1:0]        cnt_nxt [DEPTH];
    logic [ADDR_W-1:0]        rd_addr [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     underflow;
    logic                     uf_hit;
    logic                     issue_full;
    logic                     issue_ok;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Retirements hitting register r this cycle: writeback plus cancel (0..2).
    function automatic logic [1:0] dec_of(input logic [ADDR_W-1:0] r,
                                          input logic we, input logic [ADDR_W-1:0] wa,
                                          input logic cn, input logic [ADDR_W-1:0] ca);
        return {1'b0, we && (wa == r)} + {1'b0, cn && (ca == r)};
    endfunction

    // Count minus retirements, clamped at zero.
    function automatic logic [PEND_W-1:0] sat_sub(input logic [PEND_W-1:0] c, input logic [1:0] d);
        logic [PEND_W+1:0] diff;
        diff = {2'b00, c} - {{PEND_W{1'b0}}, d};
        return diff[PEND_W+1] ? '0 : diff[PEND_W-1:0];
    endfunction

    // Combinational read ports; busy already accounts for this cycle's retirements.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr[k] = bus.rd_addr_i[k*ADDR_W +: ADDR_W];
            if (is_zero(rd_addr[k])) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
            end else if ((BYPASS != 0) && bus.we_i && (bus.wa_i == rd_addr[k])) begin
                rd_data[k*DATA_W +: DATA_W] = bus.wd_i;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = regs[rd_addr[k]];
            end
            rd_busy[k] = sat_sub(cnt[rd_addr[k]],
                                 dec_of(rd_addr[k], bus.we_i, bus.wa_i,
                                        bus.cancel_i, bus.cancel_addr_i)) != '0;
        end
        // Outputs are forced to their idle values while reset is held.
        if (rst_i) begin
            rd_data = '0;
            rd_busy = '0;
        end
    end

    // A retirement to the target in the same cycle frees a slot for the issue.
    assign issue_full = bus.issue_i &&
                        (sat_sub(cnt[bus.issue_addr_i],
                                 dec_of(bus.issue_addr_i, bus.we_i, bus.wa_i,
                                        bus.cancel_i, bus.cancel_addr_i)) == CNT_MAX);
    assign issue_ok   = bus.issue_i && !issue_full && !is_zero(bus.issue_addr_i);

    always_comb begin
        uf_hit = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            cnt_nxt[r] = sat_sub(cnt[r], dec_of(ADDR_W'(r), bus.we_i, bus.wa_i,
                                                bus.cancel_i, bus.cancel_addr_i))
                       + PEND_W'(issue_ok && (bus.issue_addr_i == ADDR_W'(r)));
            if (is_zero(ADDR_W'(r))) begin
                cnt_nxt[r] = '0;
            end else if ({{PEND_W{1'b0}}, dec_of(ADDR_W'(r), bus.we_i, bus.wa_i,
                                                 bus.cancel_i, bus.cancel_addr_i)}
                         > {2'b00, cnt[r]}) begin
                uf_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < DEPTH; r++) cnt[r] <= '0;
            underflow <= 1'b0;
        end else begin
            for (int r = 0; r < DEPTH; r++) cnt[r] <= cnt_nxt[r];
            if (uf_hit) underflow <= 1'b1;
        end
    end

    // Writeback lands regardless of the pending count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
        end else if (bus.we_i && !is_zero(bus.wa_i)) begin
            regs[bus.wa_i] <= bus.wd_i;
        end
    end

    assign bus.rd_data_o     = rd_data;
    assign bus.rd_busy_o     = rd_busy;
    assign bus.issue_ready_o = rst_i || !issue_full;
    assign bus.underflow_o   = underflow;
endmodule

// File: tb/tb_pipe_regfile_sb.sv
// tb_pipe_regfile_sb
// Directed scenarios followed by randomized traffic, checked against an
// integer-array model of the register file and its pending counts. A second
// instance with BYPASS=0 shares all inputs to cover the non-forwarding read.
module tb_pipe_regfile_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;
    localparam int PMAX   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();
    pipe_regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus_nb ();

    pipe_regfile_sb #(.BYPASS(1)) dut    (.clk_i(clk), .rst_i(rst), .bus(bus));
    pipe_regfile_sb #(.BYPASS(0)) dut_nb (.clk_i(clk), .rst_i(rst), .bus(bus_nb));

    logic [ADDR_W-1:0] t_ra [NUM_RD];
    logic              t_we, t_issue, t_cancel;
    logic [ADDR_W-1:0] t_wa, t_ia, t_ca;
    logic [DATA_W-1:0] t_wd;

    assign bus.rd_addr_i     = {t_ra[1], t_ra[0]};
    assign bus.we_i          = t_we;
    assign bus.wa_i          = t_wa;
    assign bus.wd_i          = t_wd;
    assign bus.issue_i       = t_issue;
    assign bus.issue_addr_i  = t_ia;
    assign bus.cancel_i      = t_cancel;
    assign bus.cancel_addr_i = t_ca;
    assign bus_nb.rd_addr_i     = {t_ra[1], t_ra[0]};
    assign bus_nb.we_i          = t_we;
    assign bus_nb.wa_i          = t_wa;
    assign bus_nb.wd_i          = t_wd;
    assign bus_nb.issue_i       = t_issue;
    assign bus_nb.issue_addr_i  = t_ia;
    assign bus_nb.cancel_i      = t_cancel;
    assign bus_nb.cancel_addr_i = t_ca;

    // Reference model
    logic [DATA_W-1:0] m_reg [DEPTH];
    int                m_cnt [DEPTH];
    bit                m_uf;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int retire(input int a);
        return ((t_we && int'(t_wa) == a) ? 1 : 0) + ((t_cancel && int'(t_ca) == a) ? 1 : 0);
    endfunction

    function automatic int pend(input int a);
        int p;
        p = m_cnt[a] - retire(a);
        return (p < 0) ? 0 : p;
    endfunction

    function automatic logic [DATA_W-1:0] exp_rd(input int a, input bit byp);
        if (a == 0) return '0;
        if (byp && t_we && int'(t_wa) == a) return t_wd;
        return m_reg[a];
    endfunction

    task automatic idle();
        t_we = 0; t_wa = '0; t_wd = '0;
        t_issue = 0; t_ia = '0;
        t_cancel = 0; t_ca = '0;
    endtask

    task automatic check_outputs();
        for (int k = 0; k < NUM_RD; k++) begin
            int a;
            a = int'(t_ra[k]);
            chk($sformatf("rd_data%0d_r%0d", k, a), 64'(bus.rd_data_o[k*DATA_W +: DATA_W]),
                rst ? 64'd0 : 64'(exp_rd(a, 1'b1)));
            chk($sformatf("nb_rd_data%0d_r%0d", k, a), 64'(bus_nb.rd_data_o[k*DATA_W +: DATA_W]),
                rst ? 64'd0 : 64'(exp_rd(a, 1'b0)));
            chk($sformatf("rd_busy%0d_r%0d", k, a), 64'(bus.rd_busy_o[k]),
                rst ? 64'd0 : 64'(pend(a) != 0));
        end
        chk("issue_ready", 64'(bus.issue_ready_o),
            rst ? 64'd1 : 64'(!(t_issue && pend(int'(t_ia)) == PMAX)));
        chk("underflow", 64'(bus.underflow_o), rst ? 64'd0 : 64'(m_uf));
    endtask

    task automatic update_model();
        bit ready;
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin m_reg[r] = '0; m_cnt[r] = 0; end
            m_uf = 0;
            return;
        end
        ready = !(t_issue && pend(int'(t_ia)) == PMAX);
        for (int r = 1; r < DEPTH; r++) begin
            int d;
            d = retire(r);
            if (d > m_cnt[r]) begin m_uf = 1; m_cnt[r] = 0; end
            else m_cnt[r] = m_cnt[r] - d;
        end
        if (t_issue && ready && t_ia != 0) m_cnt[t_ia] = m_cnt[t_ia] + 1;
        if (t_we && t_wa != 0) m_reg[t_wa] = t_wd;
    endtask

    task automatic settle();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic adv();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    initial begin
        rst = 1;
        idle();
        t_ra[0] = '0; t_ra[1] = '0;
        for (int r = 0; r < DEPTH; r++) begin m_reg[r] = '0; m_cnt[r] = 0; end
        m_uf = 0;

        // Outputs held idle during reset, even with a forwarding write present
        tick();
        t_we = 1; t_wa = 5'd3; t_wd = 32'hCAFE_0003; t_ra[0] = 5'd3;
        t_issue = 1; t_ia = 5'd3;
        tick();
        idle();
        tick();
        rst = 0;

        // Sweep all registers after reset
        for (int i = 0; i < DEPTH; i++) begin
            t_ra[0] = 5'(i); t_ra[1] = 5'(DEPTH - 1 - i);
            tick();
        end

        // Write-through bypass on r5
        t_we = 1; t_wa = 5'd5; t_wd = 32'hDEAD_BEEF; t_ra[0] = 5'd5;
        settle();
        chk("bypass_same_cycle", 64'(bus.rd_data_o[31:0]), 64'h0000_0000_DEAD_BEEF);
        chk("nobypass_same_cycle", 64'(bus_nb.rd_data_o[31:0]), 64'd0);
        adv();
        idle();
        settle();
        chk("nobypass_next_cycle", 64'(bus_nb.rd_data_o[31:0]), 64'h0000_0000_DEAD_BEEF);
        adv();

        // Issue r7 then write it back
        t_issue = 1; t_ia = 5'd7; t_ra[0] = 5'd7;
        tick();
        idle();
        settle();
        chk("r7_busy_after_issue", 64'(bus.rd_busy_o[0]), 64'd1);
        adv();
        t_we = 1; t_wa = 5'd7; t_wd = 32'h12;
        settle();
        chk("r7_busy_in_wb", 64'(bus.rd_busy_o[0]), 64'd0);
        chk("r7_data_in_wb", 64'(bus.rd_data_o[31:0]), 64'h12);
        adv();
        idle();

        // Saturate r3, then issue alongside a writeback
        t_ra[1] = 5'd3;
        repeat (3) begin t_issue = 1; t_ia = 5'd3; tick(); end
        settle();
        chk("r3_full_not_ready", 64'(bus.issue_ready_o), 64'd0);
        adv();
        t_we = 1; t_wa = 5'd3; t_wd = 32'h333;
        settle();
        chk("r3_ready_with_wb", 64'(bus.issue_ready_o), 64'd1);
        adv();
        t_we = 0;
        settle();
        chk("r3_still_full", 64'(bus.issue_ready_o), 64'd0);
        adv();
        idle();
        repeat (3) begin t_we = 1; t_wa = 5'd3; t_wd = $urandom; tick(); end
        idle();
        tick();

        // Issue r9, cancel it, then cancel again to underflow
        t_ra[0] = 5'd9;
        t_issue = 1; t_ia = 5'd9; tick();
        idle(); t_cancel = 1; t_ca = 5'd9;
        settle();
        chk("r9_busy_cleared_by_cancel", 64'(bus.rd_busy_o[0]), 64'd0);
        adv();
        tick();
        idle();
        settle();
        chk("underflow_set", 64'(bus.underflow_o), 64'd1);
        adv();
        repeat (3) tick();

        // Register 0 ignores writes and issues
        t_we = 1; t_wa = 5'd0; t_wd = 32'hFFFF; t_issue = 1; t_ia = 5'd0; t_ra[0] = 5'd0;
        settle();
        chk("r0_reads_zero", 64'(bus.rd_data_o[31:0]), 64'd0);
        chk("r0_ready", 64'(bus.issue_ready_o), 64'd1);
        adv();
        idle();
        tick();

        // Asynchronous reset mid-cycle with two writers pending on r4
        repeat (2) begin t_issue = 1; t_ia = 5'd4; tick(); end
        idle();
        t_ra[0] = 5'd4; t_we = 1; t_wa = 5'd4; t_wd = 32'hAAAA_5555;
        #3;
        chk("r4_busy_before_reset", 64'(bus.rd_busy_o[0]), 64'd1);
        rst = 1;
        #1;
        chk("r4_busy_in_reset", 64'(bus.rd_busy_o[0]), 64'd0);
        chk("r4_data_in_reset", 64'(bus.rd_data_o[31:0]), 64'd0);
        chk("underflow_in_reset", 64'(bus.underflow_o), 64'd0);
        adv();
        rst = 0;
        idle();
        tick();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int pq[$];
            pq = {};
            for (int r = 1; r < DEPTH; r++) if (m_cnt[r] > 0) pq.push_back(r);
            t_ra[0]  = 5'($urandom_range(0, 7));
            t_ra[1]  = 5'($urandom_range(0, DEPTH - 1));
            t_issue  = ($urandom % 2) == 0;
            t_ia     = 5'($urandom_range(0, 7));
            t_wd     = $urandom;
            t_we     = ($urandom % 3) != 0;
            if (pq.size() > 0 && ($urandom % 10) != 0) t_wa = 5'(pq[$urandom % pq.size()]);
            else t_wa = 5'($urandom_range(0, DEPTH - 1));
            t_cancel = ($urandom % 6) == 0;
            if (pq.size() > 0 && ($urandom % 8) != 0) t_ca = 5'(pq[$urandom % pq.size()]);
            else t_ca = 5'($urandom_range(0, DEPTH - 1));
            tick();
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pipe_regfile_sb.md
Name: pipe_regfile_sb

Overview:
Parametrised register file with integrated scoreboard for the pipelined core. It is the successor to the fixed 2-read/1-write 32x32 register file. It adds a configurable width, depth and read-port count, plus a write-through bypass. Each register has a pending-write counter, so the ID stage detects RAW hazards and WAW in-flight writers directly. It sits in ID: it is read by decode, written from WB, and issued into from ID when an instruction with a destination enters ID/EX.

Parameters:
DATA_W, 32, data width of each register
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports
PEND_W, 2, width of per-register pending-writer counter; max in-flight writers = 2**PEND_W-1
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and issues
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous active-high reset
rd_addr_i  in  NUM_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
rd_data_o  out  NUM_RD*DATA_W  packed read data, combinational
rd_busy_o  out  NUM_RD  per-port: register has an outstanding writer after this cycle's writeback/cancel
we_i  in  1  writeback enable (from MEM/WB RegWrite)
wa_i  in  ADDR_W  writeback address
wd_i  in  DATA_W  writeback data
issue_i  in  1  request: instruction with destination issue_addr_i enters EX
issue_addr_i  in  ADDR_W  destination of issuing instruction
issue_ready_o  out  1  issue accepted this cycle
cancel_i  in  1  squashed in-flight writer; decrement without writing
cancel_addr_i  in  ADDR_W  destination of squashed writer
underflow_o  out  1  sticky error: writeback/cancel to register with zero pending count

Behaviour:
- Reset (async, rst_i=1): all registers=0, all counters=0, underflow_o=0. Outputs during reset: rd_data_o=0, rd_busy_o=0, issue_ready_o=1.
- Storage: 2**ADDR_W x DATA_W regs; cnt[r] PEND_W bits.
- Write: on clk edge, if we_i and !(ZERO_REG && wa_i==0), reg[wa_i]<=wd_i. The write occurs regardless of cnt.
- Read (combinational, 0 latency): for each port k, rd_data = 0 if ZERO_REG && addr==0. Otherwise, if BYPASS && we_i && wa_i==addr (and wa_i not zero-reg), rd_data = wd_i. Otherwise rd_data = reg[addr].
- dec[r] = (we_i && wa_i==r) + (cancel_i && cancel_addr_i==r). Both events may target the same r and decrement by 2.
- rd_busy_o[k] = (cnt[addr] - dec[addr]) != 0, using saturated-at-0 subtraction. Issue in the same cycle does not affect busy.
- issue_ready_o = !issue_i-target-full, i.e. 0 only when issue_i && cnt[issue_addr_i] - dec[issue_addr_i] == 2**PEND_W-1. The ID stage must stall while issue_i && !issue_ready_o.
- Counter update per r on clk edge: cnt <= cnt - dec + inc, where inc = issue_i && issue_ready_o && issue_addr_i==r && !(ZERO_REG && r==0).
  - If dec > cnt, the counter clamps to 0 and underflow_o <= 1.
  - Simultaneous issue and writeback to the same r leaves the count unchanged.
- underflow_o: sticky, cleared only by reset.
- Register 0 when ZERO_REG=1: cnt[0] permanently 0; busy 0; writeback/cancel to 0 never sets underflow.
- Reset mid-operation: all pending counts are lost immediately; the pipeline is reset concurrently.

Test Plan:
- Reset, then read r0..r31 on both ports -> all 0, rd_busy_o=00, issue_ready_o=1, underflow_o=0.
- Write r5=0xDEADBEEF with port0 reading r5 in the same cycle (BYPASS=1) -> rd_data port0=0xDEADBEEF that cycle; with BYPASS=0 -> 0 that cycle, 0xDEADBEEF next cycle.
- Issue r7 -> next cycle busy=1. Writeback r7=0x12 -> busy=0 in the writeback cycle (combinational) and data=0x12.
- Issue r3 three times (PEND_W=2) -> 4th issue_i sees issue_ready_o=0 and cnt stays 3. In the same cycle as a writeback to r3, a 4th issue is accepted and cnt stays 3.
- Issue r9, then cancel r9 -> busy clears, r9 value unchanged. A second cancel r9 -> underflow_o=1 and stays 1 until rst_i.
- Write/issue r0=0xFFFF with ZERO_REG=1 -> reads 0, busy 0, ready 1. Assert rst_i asynchronously mid-clock with cnt[4]=2 -> immediately busy=0 and data=0.
